kbd_num_entry: RTL and testbench

- Parametrised numeric-entry front end for the PS/2 path. It sits between KeyboardDecoder and the game logic.
- Takes decoded key events and keeps an N-digit BCD entry buffer with single-key lockout, backspace, escape and enter.
- On enter, converts the buffer to binary over several cycles and range-checks it. Reports the result as a one-cycle valid or error pulse.
- Generalises the earlier 2-digit handler to any digit count, adds editing keys, and adds a checked binary result.

---
 rtl/kbd_pkg.sv | 28 ++
 rtl/kbd_num_entry_bcd2bin_seq.sv | 66 ++++++
 rtl/kbd_num_entry.sv | 178 +++++++++++++++++
 tb/tb_kbd_num_entry.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared definitions for the numeric-entry front end: scan codes, the
// digit decoder and the conversion state encoding.
package kbd_pkg;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    localparam logic [8:0] SC_ENTER = 9'h05A;
    localparam logic [8:0] SC_BKSP  = 9'h066;
    localparam logic [8:0] SC_ESC   = 9'h076;

    // Index i of each table is the digit value i.
    localparam logic [8:0] SC_MAIN [10] = '{9'h045, 9'h016, 9'h01E, 9'h026, 9'h025,
                                            9'h02E, 9'h036, 9'h03D, 9'h03E, 9'h046};
    localparam logic [8:0] SC_KPAD [10] = '{9'h070, 9'h069, 9'h072, 9'h07A, 9'h06B,
                                            9'h073, 9'h074, 9'h06C, 9'h075, 9'h07D};

    // Returns {hit, digit}; hit is 0 for any code that is not a digit key.
    function automatic logic [4:0] scan_to_digit(input logic [8:0] code, input logic keypad_en);
        logic [4:0] r;
        r = 5'd0;
        for (int i = 0; i < 10; i++) begin
            if (code == SC_MAIN[i] || (keypad_en && code == SC_KPAD[i]))
                r = {1'b1, 4'(i)};
        end
        return r;
    endfunction

endpackage

// File: rtl/kbd_num_entry_bcd2bin_seq.sv
// Iterative BCD to binary converter: one multiply-accumulate per cycle,
// most significant digit first, with a combinational done/result on the last step.
module bcd2bin_seq #(
    parameter int NUM_DIGITS = 2,
    parameter int ACC_W      = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    start,
    input  logic [4*NUM_DIGITS-1:0] digits,
    output logic                    done,
    output logic [ACC_W-1:0]        result
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [3:0]       digit_arr [NUM_DIGITS];
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic             active_reg, active_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_split
            assign digit_arr[gi] = digits[4*gi +: 4];
        end
    endgenerate

    always_comb begin
        // acc*10 as acc*8 + acc*2; the final sum never exceeds 10^NUM_DIGITS-1.
        result      = ACC_W'({acc_reg, 3'b000}) + ACC_W'({acc_reg, 1'b0}) + ACC_W'(digit_arr[idx_reg]);
        done        = active_reg && (idx_reg == '0);
        acc_next    = acc_reg;
        idx_next    = idx_reg;
        active_next = active_reg;
        if (clr) begin
            acc_next    = '0;
            idx_next    = '0;
            active_next = 1'b0;
        end else if (start) begin
            acc_next    = '0;
            idx_next    = IDX_W'(NUM_DIGITS - 1);
            active_next = 1'b1;
        end else if (active_reg) begin
            acc_next = result;
            if (idx_reg == '0)
                active_next = 1'b0;
            else
                idx_next = idx_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg    <= '0;
            idx_reg    <= '0;
            active_reg <= 1'b0;
        end else begin
            acc_reg    <= acc_next;
            idx_reg    <= idx_next;
            active_reg <= active_next;
        end
    end

endmodule

// File: rtl/kbd_num_entry.sv
// Numeric entry front end: single-key lockout, BCD edit buffer, and an
// enter-triggered conversion that reports a range-checked binary value.
module kbd_num_entry
    import kbd_pkg::*;
#(
    parameter int NUM_DIGITS     = 2,
    parameter int MAX_VALUE      = 99,
    parameter int VAL_W          = 7,
    parameter int KEYPAD_EN      = 1,
    parameter int CLEAR_ON_ENTER = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              sync_clr,
    input  logic                              key_valid,
    input  logic [8:0]                        key_code,
    input  logic                              key_make,
    output logic [4*NUM_DIGITS-1:0]           digits,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
    output logic                              enter_pulse,
    output logic                              busy,
    output logic [VAL_W-1:0]                  value,
    output logic                              value_valid,
    output logic                              value_err
);

    localparam int          DW    = 4 * NUM_DIGITS;
    localparam int          CNT_W = $clog2(NUM_DIGITS + 1);
    localparam int          ACC_W = $clog2(10 ** NUM_DIGITS);
    localparam logic [31:0] MAX_U = MAX_VALUE;

    state_t           state_reg, state_next;
    logic             lock_reg, lock_next;
    logic [8:0]       held_reg, held_next;
    logic [DW-1:0]    digits_reg, digits_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             enter_reg, enter_next;
    logic             busy_reg, busy_next;
    logic [VAL_W-1:0] value_reg, value_next;
    logic             valid_reg, valid_next;
    logic             err_reg, err_next;

    logic [4:0]       dec;
    logic             is_enter, is_bksp, is_esc, recognised, accept;
    logic             conv_start, conv_done;
    logic [ACC_W-1:0] conv_result;

    bcd2bin_seq #(
        .NUM_DIGITS (NUM_DIGITS),
        .ACC_W      (ACC_W)
    ) u_conv (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (sync_clr),
        .start  (conv_start),
        .digits (digits_reg),
        .done   (conv_done),
        .result (conv_result)
    );

    always_comb begin
        state_next  = state_reg;
        lock_next   = lock_reg;
        held_next   = held_reg;
        digits_next = digits_reg;
        count_next  = count_reg;
        value_next  = value_reg;
        enter_next  = 1'b0;
        valid_next  = 1'b0;
        err_next    = 1'b0;
        conv_start  = 1'b0;

        dec        = scan_to_digit(key_code, KEYPAD_EN != 0);
        is_enter   = (key_code == SC_ENTER);
        is_bksp    = (key_code == SC_BKSP);
        is_esc     = (key_code == SC_ESC);
        recognised = dec[4] | is_enter | is_bksp | is_esc;
        accept     = key_valid & key_make & recognised & ~lock_reg;

        // Lock tracking runs regardless of conversion state.
        if (accept) begin
            lock_next = 1'b1;
            held_next = key_code;
        end else if (key_valid && !key_make && lock_reg && key_code == held_reg) begin
            lock_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (dec[4]) begin
                        digits_next = DW'({digits_reg, dec[3:0]});
                        if (count_reg != CNT_W'(NUM_DIGITS))
                            count_next = count_reg + 1'b1;
                    end else if (is_bksp) begin
                        digits_next = digits_reg >> 4;
                        if (count_reg != '0)
                            count_next = count_reg - 1'b1;
                    end else if (is_esc) begin
                        digits_next = '0;
                        count_next  = '0;
                    end else begin
                        enter_next = 1'b1;
                        conv_start = 1'b1;
                        state_next = CONV;
                    end
                end
            end
            CONV: begin
                if (conv_done) begin
                    state_next = DONE;
                    if (count_reg == '0 || 32'(conv_result) > MAX_U) begin
                        err_next = 1'b1;
                    end else begin
                        value_next = VAL_W'(conv_result);
                        valid_next = 1'b1;
                    end
                    if (CLEAR_ON_ENTER != 0) begin
                        digits_next = '0;
                        count_next  = '0;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Interboard clear wipes everything except the last accepted value.
        if (sync_clr) begin
            state_next  = IDLE;
            lock_next   = 1'b0;
            held_next   = '0;
            digits_next = '0;
            count_next  = '0;
            value_next  = value_reg;
            enter_next  = 1'b0;
            valid_next  = 1'b0;
            err_next    = 1'b0;
        end

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            lock_reg   <= 1'b0;
            held_reg   <= '0;
            digits_reg <= '0;
            count_reg  <= '0;
            enter_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            value_reg  <= '0;
            valid_reg  <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            lock_reg   <= lock_next;
            held_reg   <= held_next;
            digits_reg <= digits_next;
            count_reg  <= count_next;
            enter_reg  <= enter_next;
            busy_reg   <= busy_next;
            value_reg  <= value_next;
            valid_reg  <= valid_next;
            err_reg    <= err_next;
        end
    end

    assign digits      = digits_reg;
    assign digit_count = count_reg;
    assign enter_pulse = enter_reg;
    assign busy        = busy_reg;
    assign value       = value_reg;
    assign value_valid = valid_reg;
    assign value_err   = err_reg;

endmodule

// File: tb/tb_kbd_num_entry.sv
// Bench for kbd_num_entry: two instances (default and 3-digit/255/no-keypad)
// share stimulus and are compared each cycle against a decimal-list model.
module tb_kbd_num_entry;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sync_clr = 1'b0;
    logic       key_valid = 1'b0;
    logic       key_make = 1'b0;
    logic [8:0] key_code = 9'h0;

    logic [7:0]  digits0;  logic [1:0] count0; logic enter0, busy0, vv0, ve0; logic [6:0] value0;
    logic [11:0] digits1;  logic [1:0] count1; logic enter1, busy1, vv1, ve1; logic [7:0] value1;

    always #5 clk = ~clk;

    kbd_num_entry dut0 (
        .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .key_valid(key_valid),
        .key_code(key_code), .key_make(key_make), .digits(digits0), .digit_count(count0),
        .enter_pulse(enter0), .busy(busy0), .value(value0), .value_valid(vv0), .value_err(ve0)
    );

    kbd_num_entry #(.NUM_DIGITS(3), .MAX_VALUE(255), .VAL_W(8), .KEYPAD_EN(0), .CLEAR_ON_ENTER(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .key_valid(key_valid),
        .key_code(key_code), .key_make(key_make), .digits(digits1), .digit_count(count1),
        .enter_pulse(enter1), .busy(busy1), .value(value1), .value_valid(vv1), .value_err(ve1)
    );

    localparam int K_ENT = 'h5A, K_BS = 'h66, K_ESC = 'h76;
    int main_codes[10] = '{'h45, 'h16, 'h1E, 'h26, 'h25, 'h2E, 'h36, 'h3D, 'h3E, 'h46};
    int kpad_codes[10] = '{'h70, 'h69, 'h72, 'h7A, 'h6B, 'h73, 'h74, 'h6C, 'h75, 'h7D};
    int NP[2] = '{2, 3};
    int MP[2] = '{99, 255};
    bit KP[2] = '{1'b1, 1'b0};

    // Model: digits held as a decimal list, oldest first.
    int dg[2][8];
    int dn[2], hc[2], ph[2], ev[2];
    bit lk[2], e_ent[2], e_vld[2], e_err[2];

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       kv;
        logic [8:0] code;
        logic       mk;
        logic       clr;
    } ev_t;
    ev_t evq[$];

    function automatic int digit_of(int code, bit kp);
        for (int i = 0; i < 10; i++) begin
            if (code == main_codes[i]) return i;
            if (kp && code == kpad_codes[i]) return i;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            dn[m] = 0; hc[m] = 0; ph[m] = 0; ev[m] = 0;
            lk[m] = 0; e_ent[m] = 0; e_vld[m] = 0; e_err[m] = 0;
        end
    endfunction

    function automatic void model_step(int m);
        int  d, num;
        bit  busy_now, rec;
        e_ent[m] = 0; e_vld[m] = 0; e_err[m] = 0;
        if (sync_clr) begin
            dn[m] = 0; lk[m] = 0; ph[m] = 0;
            return;
        end
        busy_now = (ph[m] != 0);
        if (ph[m] != 0) begin
            ph[m]++;
            if (ph[m] == NP[m] + 1) begin
                num = 0;
                for (int k = 0; k < dn[m]; k++) num = num * 10 + dg[m][k];
                if (dn[m] == 0 || num > MP[m]) e_err[m] = 1;
                else begin ev[m] = num; e_vld[m] = 1; end
            end else if (ph[m] == NP[m] + 2) begin
                ph[m] = 0;
            end
        end
        if (!key_valid) return;
        d   = digit_of(int'(key_code), KP[m]);
        rec = (d >= 0) || key_code == 9'(K_ENT) || key_code == 9'(K_BS) || key_code == 9'(K_ESC);
        if (key_make && rec && !lk[m]) begin
            lk[m] = 1; hc[m] = int'(key_code);
            if (!busy_now) begin
                if (d >= 0) begin
                    if (dn[m] == NP[m]) begin
                        for (int k = 0; k < dn[m] - 1; k++) dg[m][k] = dg[m][k+1];
                        dn[m]--;
                    end
                    dg[m][dn[m]] = d;
                    dn[m]++;
                end else if (key_code == 9'(K_BS)) begin
                    if (dn[m] > 0) dn[m]--;
                end else if (key_code == 9'(K_ESC)) begin
                    dn[m] = 0;
                end else begin
                    ph[m] = 1; e_ent[m] = 1;
                end
            end
        end else if (!key_make && lk[m] && int'(key_code) == hc[m]) begin
            lk[m] = 0;
        end
    endfunction

    function automatic logic [63:0] exp_pack(int m);
        logic [31:0] dv;
        dv = '0;
        for (int k = 0; k < dn[m]; k++) dv[4*k +: 4] = 4'(dg[m][dn[m]-1-k]);
        return {dv, 4'(dn[m]), e_ent[m], ph[m] != 0, 16'(ev[m]), 8'h0, e_vld[m], e_err[m]};
    endfunction

    function automatic logic [63:0] obs_pack(int m);
        if (m == 0) return {24'h0, digits0, 2'b0, count0, enter0, busy0, 9'h0, value0, 8'h0, vv0, ve0};
        return {20'h0, digits1, 2'b0, count1, enter1, busy1, 8'h0, value1, 8'h0, vv1, ve1};
    endfunction

    function automatic void push_ev(bit kv, int code, bit mk, bit clr);
        ev_t e;
        e.kv = kv; e.code = 9'(code); e.mk = mk; e.clr = clr;
        evq.push_back(e);
    endfunction
    function automatic void press(int c);   push_ev(1, c, 1, 0); endfunction
    function automatic void release_k(int c); push_ev(1, c, 0, 0); endfunction
    function automatic void idle_n(int n);  for (int i = 0; i < n; i++) push_ev(0, 0, 0, 0); endfunction
    function automatic void tap(int c);     press(c); idle_n(1); release_k(c); idle_n(1); endfunction

    task automatic do_ev(input ev_t e);
        key_valid = e.kv; key_code = e.code; key_make = e.mk; sync_clr = e.clr;
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        key_valid = 1'b0; sync_clr = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs_pack(m) !== exp_pack(m)) begin
                errors++;
                $display("FAIL reset inst%0d got=%h exp=%h", m, obs_pack(m), exp_pack(m));
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc = 0, t_ent = -1, t_vld = -1, n_err = 0;
        evq.delete();
        tap('h26); tap('h3D); press(K_ENT); idle_n(1); release_k(K_ENT); idle_n(5);
        while (evq.size() > 0) begin
            do_ev(evq.pop_front()); cyc++;
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs_pack(m) !== exp_pack(m)) begin
                    errors++;
                    $display("FAIL basic inst%0d cyc%0d got=%h exp=%h", m, cyc, obs_pack(m), exp_pack(m));
                end
            end
            if (enter0) t_ent = cyc;
            if (vv0) t_vld = cyc;
            if (ve0) n_err++;
        end
        checks++;
        if (t_vld - t_ent !== 2 || t_ent < 0) begin
            errors++; $display("FAIL basic_latency got=%0d exp=2", t_vld - t_ent);
        end
        checks++;
        if (digits0 !== 8'h37 || value0 !== 7'd37 || n_err !== 0) begin
            errors++; $display("FAIL basic_value got=%h/%0d/%0d exp=37/37/0", digits0, value0, n_err);
        end
    endtask

    task automatic test_lockout();
        int cyc = 0;
        evq.delete();
        tap(K_ESC); press('h2E);
        for (int i = 0; i < 4; i++) press('h2E);
        press('h1E); release_k('h2E); idle_n(2);
        while (evq.size() > 0) begin
            do_ev(evq.pop_front()); cyc++;
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs_pack(m) !== exp_pack(m)) begin
                    errors++;
                    $display("FAIL lockout inst%0d cyc%0d got=%h exp=%h", m, cyc, obs_pack(m), exp_pack(m));
                end
            end
        end
        checks++;
        if (digits0 !== 8'h05 || count0 !== 2'd1 || digits1 !== 12'h005) begin
            errors++; $display("FAIL lockout_digits got=%h/%0d/%h exp=05/1/005", digits0, count0, digits1);
        end
    endtask

    task automatic test_range();
        int cyc = 0, n_err1 = 0, n_vld1 = 0;
        evq.delete();
        tap(K_ESC); tap('h1E); tap('h2E); tap('h36); tap(K_ENT); idle_n(5);
        tap(K_BS); tap('h2E); tap(K_ENT); idle_n(5);
        while (evq.size() > 0) begin
            do_ev(evq.pop_front()); cyc++;
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs_pack(m) !== exp_pack(m)) begin
                    errors++;
                    $display("FAIL range inst%0d cyc%0d got=%h exp=%h", m, cyc, obs_pack(m), exp_pack(m));
                end
            end
            if (ve1) n_err1++;
            if (vv1) n_vld1++;
        end
        checks++;
        if (value1 !== 8'd255 || value0 !== 7'd55 || n_err1 !== 1 || n_vld1 !== 1) begin
            errors++;
            $display("FAIL range_result got=%0d/%0d/%0d/%0d exp=255/55/1/1", value1, value0, n_err1, n_vld1);
        end
    endtask

    task automatic test_empty_and_edit();
        int cyc = 0, mark, n_err0 = 0;
        logic [7:0] snap = 8'h0;
        evq.delete();
        tap(K_ESC); tap(K_ENT); idle_n(5);
        tap('h16); tap('h1E); tap('h26);
        mark = evq.size();
        tap(K_ESC);
        while (evq.size() > 0) begin
            do_ev(evq.pop_front()); cyc++;
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs_pack(m) !== exp_pack(m)) begin
                    errors++;
                    $display("FAIL edit inst%0d cyc%0d got=%h exp=%h", m, cyc, obs_pack(m), exp_pack(m));
                end
            end
            if (ve0) n_err0++;
            if (cyc == mark) snap = digits0;
        end
        checks++;
        if (snap !== 8'h23 || n_err0 !== 1 || digits0 !== 8'h00 || count0 !== 2'd0) begin
            errors++;
            $display("FAIL edit_result got=%h/%0d/%h/%0d exp=23/1/00/0", snap, n_err0, digits0, count0);
        end
    endtask

    task automatic test_keypad();
        int cyc = 0;
        evq.delete();
        tap(K_ESC); tap('h7A); tap('h1E); idle_n(1);
        press('h7A); press('h1E); release_k('h1E); release_k('h7A); idle_n(1);
        while (evq.size() > 0) begin
            do_ev(evq.pop_front()); cyc++;
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs_pack(m) !== exp_pack(m)) begin
                    errors++;
                    $display("FAIL keypad inst%0d cyc%0d got=%h exp=%h", m, cyc, obs_pack(m), exp_pack(m));
                end
            end
            if (cyc == 13 && digits0 !== 8'h32) begin
                errors++; $display("FAIL keypad_mix got=%h exp=32", digits0);
            end
        end
        checks++;
        if (digits1 !== 12'h022 || digits0 !== 8'h23) begin
            errors++; $display("FAIL keypad_lock got=%h/%h exp=022/23", digits1, digits0);
        end
    endtask

    task automatic test_busy_drop();
        int cyc = 0;
        evq.delete();
        tap(K_ESC); tap('h25); press(K_ENT); release_k(K_ENT); press('h46); release_k('h46); idle_n(5);
        while (evq.size() > 0) begin
            do_ev(evq.pop_front()); cyc++;
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs_pack(m) !== exp_pack(m)) begin
                    errors++;
                    $display("FAIL busy inst%0d cyc%0d got=%h exp=%h", m, cyc, obs_pack(m), exp_pack(m));
                end
            end
        end
        checks++;
        if (digits0 !== 8'h04 || digits1 !== 12'h004 || value0 !== 7'd4) begin
            errors++; $display("FAIL busy_drop got=%h/%h/%0d exp=04/004/4", digits0, digits1, value0);
        end
    endtask

    task automatic test_sync_clr();
        int cyc = 0, n_pulse = 0;
        evq.delete();
        tap(K_ESC); tap('h3E); press(K_ENT); idle_n(1); push_ev(0, 0, 0, 1); idle_n(5); release_k(K_ENT);
        while (evq.size() > 0) begin
            do_ev(evq.pop_front()); cyc++;
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs_pack(m) !== exp_pack(m)) begin
                    errors++;
                    $display("FAIL syncclr inst%0d cyc%0d got=%h exp=%h", m, cyc, obs_pack(m), exp_pack(m));
                end
            end
            n_pulse += int'(vv0) + int'(ve0) + int'(vv1) + int'(ve1);
        end
        checks++;
        if (n_pulse !== 0 || busy0 !== 1'b0 || digits0 !== 8'h0 || value0 !== 7'd4) begin
            errors++;
            $display("FAIL syncclr_result got=%0d/%b/%h/%0d exp=0/0/00/4", n_pulse, busy0, digits0, value0);
        end
    endtask

    task automatic test_random();
        int pool[26] = '{'h45, 'h16, 'h1E, 'h26, 'h25, 'h2E, 'h36, 'h3D, 'h3E, 'h46, 'h70, 'h69, 'h72,
                         'h7A, 'h5A, 'h5A, 'h66, 'h76, 'h15A, 'h17A, 'h11C, 'h029, 'h6C, 'h75, 'h5A, 'h66};
        int last = 'h45, r, c;
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            evq.delete();
            if (r < 2) push_ev(0, 0, 0, 1);
            else if (r < 40) idle_n(1);
            else if (r < 70) begin
                c = pool[$urandom_range(0, 25)];
                last = c;
                press(c);
            end else begin
                c = ($urandom_range(0, 9) < 7) ? last : pool[$urandom_range(0, 25)];
                release_k(c);
            end
            do_ev(evq.pop_front());
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs_pack(m) !== exp_pack(m)) begin
                    errors++;
                    $display("FAIL random inst%0d step%0d got=%h exp=%h", m, i, obs_pack(m), exp_pack(m));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        evq.delete();
        tap('h46); idle_n(1);
        while (evq.size() > 0) do_ev(evq.pop_front());
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs_pack(m) !== exp_pack(m)) begin
                errors++;
                $display("FAIL async_reset inst%0d got=%h exp=%h", m, obs_pack(m), exp_pack(m));
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lockout();
        test_range();
        test_empty_and_edit();
        test_keypad();
        test_busy_drop();
        test_sync_clr();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
